imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the instruction memory. Receives a byte stream (boot/debug link) and assembles little-endian 32-bit words. Writes them into instruction memory at consecutive byte addresses 0, 4, 8, ...
- Holds the core in reset until the program image is loaded, then flags completion.
- Sits between the byte link and the instruction memory write port, in the instruction memory's clock domain.

Parameters:
INS, 64, instruction memory depth in 32-bit words; maximum loadable word count
ADDR_W, 32, width of mem_addr (byte address)

Ports:
del_clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
byte_data  input  8  incoming stream byte
byte_valid  input  1  byte_data valid this cycle
byte_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  one-cycle write strobe to instruction memory
mem_addr  output  ADDR_W  byte address of word being written (multiple of 4)
mem_wdata  output  32  assembled word, first received byte in [7:0]
words_loaded  output  16  count of words written so far
core_hold  output  1  high while loading; keeps CPU in reset
load_done  output  1  image loaded successfully (sticky until rst)
load_err  output  1  image rejected (sticky until rst)

Behaviour:
- Reset (rst=1 at posedge): state=HDR0, byte_ready=0 during reset cycle, mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, core_hold=1, load_done=0, load_err=0, byte counter=0, assembly register cleared.
- Transfer occurs only on a posedge with byte_valid && byte_ready. byte_ready is registered-state driven, not combinationally dependent on byte_valid.
- Stream format: 2-byte word count N (little-endian: first byte = N[7:0]), then 4*N payload bytes.
- States:
  - HDR0: ready=1; on transfer latch N[7:0] -> HDR1.
  - HDR1: ready=1; on transfer latch N[15:8].
    - If full N > INS -> ERR.
    - Else if N==0 -> DONE (or CSUM with CHECKSUM_EN).
    - Else -> DATA.
  - DATA: ready=1; byte k (k=0..3) of the current word goes to bits [8k+7:8k]. On transfer of byte 3 -> WRITE.
  - WRITE: ready=0; mem_we=1 for exactly this cycle; mem_addr=4*words_loaded; mem_wdata=assembled word. At the end of the cycle words_loaded increments. If words_loaded+1==N -> DONE (or CSUM), else -> DATA.
  - DONE: ready=0, core_hold=0, load_done=1; stays until rst.
  - ERR: ready=0, core_hold=1, load_err=1, mem_we never asserted; stays until rst.
- Latency: byte 3 accepted at edge t -> mem_we high during cycle t..t+1 -> next byte accepted at edge t+2 at earliest. Peak throughput is 4 bytes per 5 cycles.
- byte_valid gaps: state and partial word are held indefinitely; no timeout.
- mem_addr and mem_wdata hold their last written values outside WRITE; consumers qualify with mem_we only.
- byte_valid while ready=0 (WRITE/DONE/ERR): byte is not consumed; the source must hold it (WRITE) or it is ignored (DONE/ERR).
- Mid-operation reset: returns to HDR0 the next cycle. Partial word is discarded with no write; words already written are not erased. core_hold stays 1 throughout.
- N==INS is legal (fills memory exactly). mem_addr never exceeds 4*(INS-1).
- words_loaded width is 16 bits; no wrap is possible because N<=INS<65536.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes is maintained; it is cleared on rst and header bytes are excluded.
  - After the last WRITE (or after HDR1 when N==0), the loader enters CSUM with ready=1 and accepts exactly one byte.
  - If the byte equals the running XOR -> DONE, else -> ERR.
- Undefined: no CSUM state and no XOR logic; the loader goes directly to DONE after the last write.

Test Plan:
- Reset values: hold rst 3 cycles -> byte_ready=0 during reset, then 1 in HDR0; mem_we=0, core_hold=1, load_done=0, load_err=0, words_loaded=0.
- Two-word load, bytes 02 00 13 05 A0 00 93 05 B0 00, valid every cycle -> mem_we pulses with (addr 0x0, data 0x00A00513) and (addr 0x4, data 0x00B00593). words_loaded=2, load_done=1, core_hold=0.
- Header 00 00 -> DONE right after HDR1 with no mem_we (with checksum enabled: send 00 -> DONE).
- With INS=64, header 41 00 (N=65) -> load_err=1, byte_ready=0, core_hold=1, no mem_we ever. Header 40 00 plus 256 bytes -> last write at addr 0xFC, load_done=1.
- Random byte_valid gaps, and byte_valid held high during WRITE -> no byte lost or duplicated; data identical to the gap-free run.
- rst asserted after 2 payload bytes of word 1 -> no write for the partial word. A fresh 1-word stream then writes addr 0x0 correctly. With IMEM_LOADER_CHECKSUM_EN: wrong checksum byte -> load_err=1, load_done=0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory: count header, little-endian word assembly, core hold.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned INS    = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              del_clk,
    input  logic              rst,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [15:0]       words_loaded,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FINAL = S_CSUM;
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t             state_q, next_state;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   n_full_c;
    logic [1:0]         byte_cnt_q;
    logic [31:0]        asm_q, asm_nx;
    logic               ready_nx;
    logic               xfer_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         xor_q;
`endif

    assign xfer_c   = byte_valid && byte_ready;
    assign n_full_c = {byte_data, n_q[7:0]};

    // State register
    always_ff @(posedge del_clk) begin
        if (rst) state_q <= S_HDR0;
        else     state_q <= next_state;
    end

    // Next-state, next ready and next assembled word
    always_comb begin
        next_state = state_q;
        ready_nx   = 1'b0;
        asm_nx     = asm_q;
        case (state_q)
            S_HDR0: if (xfer_c) next_state = S_HDR1;
            S_HDR1: begin
                if (xfer_c) begin
                    if (n_full_c > CNT_W'(INS))   next_state = S_ERR;
                    else if (n_full_c == '0)      next_state = S_FINAL;
                    else                          next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer_c) begin
                    asm_nx[{byte_cnt_q, 3'b000} +: 8] = byte_data;
                    if (byte_cnt_q == 2'd3) next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if ((words_loaded + 16'd1) == n_q) next_state = S_FINAL;
                else                               next_state = S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer_c) next_state = (byte_data == xor_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE:  next_state = S_DONE;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_HDR0;
        endcase
        case (next_state)
            S_HDR0, S_HDR1, S_DATA: ready_nx = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:                 ready_nx = 1'b1;
`endif
            default:                ready_nx = 1'b0;
        endcase
    end

    // Registered outputs and datapath; outputs track the state being entered
    always_ff @(posedge del_clk) begin
        if (rst) begin
            byte_ready   <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            core_hold    <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            n_q          <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            byte_ready <= ready_nx;
            mem_we     <= (next_state == S_WRITE);
            core_hold  <= (next_state != S_DONE);
            load_done  <= (next_state == S_DONE);
            load_err   <= (next_state == S_ERR);
            asm_q      <= asm_nx;
            if (state_q == S_HDR0 && xfer_c) n_q[7:0]  <= byte_data;
            if (state_q == S_HDR1 && xfer_c) n_q[15:8] <= byte_data;
            if (state_q == S_DATA && xfer_c) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_q      <= xor_q ^ byte_data;
`endif
                if (byte_cnt_q == 2'd3) begin
                    mem_wdata <= asm_nx;
                    mem_addr  <= ADDR_W'({words_loaded, 2'b00});
                end
            end
            if (state_q == S_WRITE) words_loaded <= words_loaded + 16'd1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; expected writes derived from the byte stream itself.
module tb_imem_loader;

    localparam int unsigned INS    = 64;
    localparam int unsigned ADDR_W = 32;

    logic              del_clk = 1'b0;
    logic              rst;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [15:0]       words_loaded;
    logic              core_hold;
    logic              load_done;
    logic              load_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  stim[$];
    logic [31:0] wr_addr[$], wr_data[$];
    logic [31:0] exp_addr[$], exp_data[$];

    imem_loader #(.INS(INS), .ADDR_W(ADDR_W)) dut (
        .del_clk(del_clk), .rst(rst),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .words_loaded(words_loaded), .core_hold(core_hold),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 del_clk = ~del_clk;

    // Capture every memory write strobe
    always @(negedge del_clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    // Stream: 16-bit LE count, 4*n random payload bytes, optional XOR byte
    function automatic void build(input int n, input bit good_csum);
        logic [7:0] x, b;
        logic [15:0] nn;
        nn = 16'(n);
        x = 8'h00;
        stim.delete();
        stim.push_back(nn[7:0]);
        stim.push_back(nn[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stim.push_back(b);
            x = x ^ b;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(good_csum ? x : (x ^ 8'(1 + $urandom_range(0, 254))));
`else
        if (!good_csum) stim.push_back(x);
`endif
    endfunction

    // Reference: word i sits at byte 4i, first received byte lowest
    function automatic void model();
        int n;
        n = int'({stim[1], stim[0]});
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(32'(4 * i));
            exp_data.push_back({stim[4*i+5], stim[4*i+4], stim[4*i+3], stim[4*i+2]});
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        repeat (2) @(negedge del_clk);
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        @(negedge del_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 2) == 0) begin
            byte_valid = 1'b0;
            byte_data = 8'($urandom);
            repeat ($urandom_range(1, 4)) @(negedge del_clk);
        end
        byte_valid = 1'b1;
        byte_data = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge del_clk);
            t++;
        end
        if (t == 50) begin
            n_checks++;
            $display("FAIL ready_timeout: byte_ready=%b, required 1 within 50 cycles", byte_ready);
        end
        @(negedge del_clk);
    endtask

    task automatic send_stream(input int count, input bit gaps);
        for (int i = 0; i < count; i++) send_byte(stim[i], gaps);
        byte_valid = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (load_done !== 1'b1 && load_err !== 1'b1 && t < 100) begin
            @(negedge del_clk);
            t++;
        end
        if (t == 100) begin
            n_checks++;
            $display("FAIL end_timeout: done=%b err=%b, required one of them high", load_done, load_err);
        end
        repeat (3) @(negedge del_clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'hAA;
        repeat (3) @(negedge del_clk);
        n_checks++;
        if ({byte_ready, mem_we, core_hold, load_done, load_err} !== 5'b00100)
            $display("FAIL reset_flags: rdy,we,hold,done,err=%b, required 00100",
                     {byte_ready, mem_we, core_hold, load_done, load_err});
        else n_pass++;
        n_checks++;
        if (words_loaded !== 16'd0 || mem_addr !== '0 || mem_wdata !== 32'd0)
            $display("FAIL reset_regs: words=%0d addr=%h data=%h, required 0 0 0",
                     words_loaded, mem_addr, mem_wdata);
        else n_pass++;
        byte_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge del_clk);
        n_checks++;
        if (byte_ready !== 1'b1 || core_hold !== 1'b1)
            $display("FAIL hdr0_ready: ready=%b hold=%b, required 1 1", byte_ready, core_hold);
        else n_pass++;
    endtask

    task automatic test_two_word();
        logic [7:0] x;
        logic [15:0] wl;
        do_reset();
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        x = 8'h00;
        for (int i = 2; i < 10; i++) x = x ^ stim[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        stim.push_back(x);
`endif
        send_stream(stim.size(), 1'b0);
        wait_end();
        n_checks++;
        if (wr_addr.size() != 2) $display("FAIL two_word_count: writes=%0d, required 2", wr_addr.size());
        else begin
            n_pass++;
            n_checks++;
            if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00A00513)
                $display("FAIL two_word_w0: addr=%h data=%h, required 0 00a00513", wr_addr[0], wr_data[0]);
            else n_pass++;
            n_checks++;
            if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h00B00593)
                $display("FAIL two_word_w1: addr=%h data=%h, required 4 00b00593", wr_addr[1], wr_data[1]);
            else n_pass++;
        end
        n_checks++;
        if (words_loaded !== 16'd2 || load_done !== 1'b1 || core_hold !== 1'b0 || load_err !== 1'b0)
            $display("FAIL two_word_end: words=%0d done=%b hold=%b err=%b, required 2 1 0 0",
                     words_loaded, load_done, core_hold, load_err);
        else n_pass++;
        // Bytes offered after completion are ignored
        wl = words_loaded;
        byte_valid = 1'b1;
        repeat (6) @(negedge del_clk);
        byte_valid = 1'b0;
        n_checks++;
        if (wr_addr.size() != 2 || words_loaded !== wl || byte_ready !== 1'b0 || load_done !== 1'b1)
            $display("FAIL done_ignores: writes=%0d words=%0d ready=%b done=%b, required 2 %0d 0 1",
                     wr_addr.size(), words_loaded, byte_ready, load_done, wl);
        else n_pass++;
    endtask

    task automatic test_zero_count();
        do_reset();
        build(0, 1'b1);
        send_stream(stim.size(), 1'b0);
        wait_end();
        n_checks++;
        if (wr_addr.size() != 0 || load_done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 16'd0)
            $display("FAIL zero_count: writes=%0d done=%b hold=%b words=%0d, required 0 1 0 0",
                     wr_addr.size(), load_done, core_hold, words_loaded);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        build(INS + 1, 1'b1);
        send_stream(2, 1'b0);
        repeat (3) @(negedge del_clk);
        byte_valid = 1'b1;
        repeat (8) @(negedge del_clk);
        byte_valid = 1'b0;
        n_checks++;
        if (load_err !== 1'b1 || load_done !== 1'b0 || byte_ready !== 1'b0 || core_hold !== 1'b1)
            $display("FAIL overflow_flags: err=%b done=%b ready=%b hold=%b, required 1 0 0 1",
                     load_err, load_done, byte_ready, core_hold);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() != 0) $display("FAIL overflow_writes: writes=%0d, required 0", wr_addr.size());
        else n_pass++;
    endtask

    task automatic test_full();
        int errs;
        do_reset();
        build(INS, 1'b1);
        model();
        send_stream(stim.size(), 1'b0);
        wait_end();
        errs = 0;
        if (wr_addr.size() != exp_addr.size()) errs++;
        else for (int i = 0; i < exp_addr.size(); i++)
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) errs++;
        n_checks++;
        if (errs != 0) $display("FAIL full_data: %0d bad words of %0d writes, required 0 of %0d",
                                errs, wr_addr.size(), exp_addr.size());
        else n_pass++;
        n_checks++;
        if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== 32'hFC || load_done !== 1'b1
            || words_loaded !== 16'(INS))
            $display("FAIL full_end: last_addr=%h done=%b words=%0d, required fc 1 %0d",
                     wr_addr.size() ? wr_addr[wr_addr.size()-1] : 32'hx, load_done, words_loaded, INS);
        else n_pass++;
    endtask

    task automatic test_random_gaps();
        int n, errs;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            n = $urandom_range(1, 10);
            build(n, 1'b1);
            model();
            send_stream(stim.size(), 1'b1);
            wait_end();
            errs = 0;
            if (wr_addr.size() != exp_addr.size()) errs++;
            else for (int i = 0; i < exp_addr.size(); i++)
                if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) errs++;
            n_checks++;
            if (errs != 0 || load_done !== 1'b1 || words_loaded !== 16'(n))
                $display("FAIL gaps_run%0d: bad=%0d writes=%0d done=%b words=%0d, required 0 %0d 1 %0d",
                         it, errs, wr_addr.size(), load_done, words_loaded, n, n);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        build(2, 1'b1);
        send_stream(4, 1'b0);
        n_checks++;
        if (core_hold !== 1'b1) $display("FAIL mid_hold_loading: hold=%b, required 1", core_hold);
        else n_pass++;
        rst = 1'b1;
        @(negedge del_clk);
        n_checks++;
        if (core_hold !== 1'b1 || byte_ready !== 1'b0 || wr_addr.size() != 0)
            $display("FAIL mid_reset: hold=%b ready=%b writes=%0d, required 1 0 0",
                     core_hold, byte_ready, wr_addr.size());
        else n_pass++;
        rst = 1'b0;
        @(negedge del_clk);
        build(1, 1'b1);
        model();
        send_stream(stim.size(), 1'b0);
        wait_end();
        n_checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== exp_data[0]
            || load_done !== 1'b1 || words_loaded !== 16'd1)
            $display("FAIL mid_reload: writes=%0d addr=%h data=%h done=%b, required 1 0 %h 1",
                     wr_addr.size(), wr_addr.size() ? wr_addr[0] : 32'hx,
                     wr_data.size() ? wr_data[0] : 32'hx, load_done, exp_data[0]);
        else n_pass++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        do_reset();
        build(3, 1'b0);
        send_stream(stim.size(), 1'b0);
        wait_end();
        n_checks++;
        if (load_err !== 1'b1 || load_done !== 1'b0 || core_hold !== 1'b1 || wr_addr.size() != 3)
            $display("FAIL bad_csum: err=%b done=%b hold=%b writes=%0d, required 1 0 1 3",
                     load_err, load_done, core_hold, wr_addr.size());
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        test_reset();
        test_two_word();
        test_zero_count();
        test_overflow();
        test_full();
        test_random_gaps();
        test_mid_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
